sync_fifo: RTL

Parametrised single-clock FIFO; next generation of the team's byte FIFO used between the UART and the CPU memory-mapped I/O. Adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, and write-through-on-full when a read pops in the same cycle. It supports non-power-of-two depth and an optional first-word-fall-through read mode. It drops in wherever the existing FIFO sits (UART RX/TX, MMIO buffers).

---
 rtl/fifo_pkg.sv | 32 +++
 rtl/fifo_ram.sv | 62 ++++++
 rtl/sync_fifo.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for sync_fifo and its storage sub-module fifo_ram.
//   - default width/depth/threshold constants
//   - occupancy-width helper (count needs one more bit than a pointer so it
//     can represent a completely full FIFO)
//   - pointer-wrap helper for arbitrary (non power-of-two) depths
//
// Build option FIFO_FWFT_EN:
//   left undefined by default -> registered-read (standard) mode
//   define it                 -> first-word fall-through mode
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int DEFAULT_WIDTH         = 8;
   localparam int DEFAULT_DEPTH         = 32;
   localparam int DEFAULT_AEMPTY_THRESH = 4;
   localparam int DEFAULT_AFULL_MARGIN  = 4;

   // Occupancy runs 0..DEPTH, so it needs one extra bit over a pointer.
   function automatic int occupancy_width(input int ptr_width);
      return ptr_width + 1;
   endfunction

   // Advance a pointer, wrapping explicitly at depth-1 so that depths which
   // are not a power of two never address beyond the last entry.
   function automatic int unsigned wrap_next(input int unsigned ptr,
                                             input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// DEPTH x WIDTH storage array for sync_fifo. Write port is synchronous.
// Read port is registered (with reset to zero) in the standard build and a
// plain asynchronous read when FIFO_FWFT_EN is defined.
// Storage contents are never reset.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset (read register only)
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe (loads the read register in standard mode)
//   rd_addr  in   read address
//   rd_data  out  read data
// -----------------------------------------------------------------------------
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage write. Kept free of reset so the array maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

`ifdef FIFO_FWFT_EN
   // Fall-through: the head entry is always visible on the read port, so the
   // read strobe and reset play no part in the read path.
   logic unused_rd_ctrl;
   assign unused_rd_ctrl = rst | rd_en;
   assign rd_data = mem[rd_addr];
`else
   // Registered read. A same-cycle write to the address being read returns
   // the old contents, which is what write-through-at-full relies on.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end
`endif

endmodule

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-
// empty thresholds, sticky overflow/underflow flags and write-through when
// full and a read is accepted in the same cycle. DEPTH may be any value >= 2.
//
// Build option FIFO_FWFT_EN: define for first-word fall-through (dout shows
// the head word whenever the FIFO is not empty, rd_en acknowledges it);
// undefined gives a registered dout with a one-cycle valid pulse per read.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   wr_en / din   in   write request and data
//   full          out  count == DEPTH
//   almost_full   out  count >= AFULL_THRESH
//   rd_en         in   read request
//   dout          out  read data
//   valid         out  dout holds a freshly popped word (FWFT: !empty)
//   empty         out  count == 0
//   almost_empty  out  count <= AEMPTY_THRESH
//   count         out  occupancy 0..DEPTH
//   overflow      out  sticky, a write was rejected
//   underflow     out  sticky, a read was rejected
//   clr_err       in   synchronous clear of overflow/underflow
// -----------------------------------------------------------------------------
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int WIDTH         = DEFAULT_WIDTH,
   parameter int DEPTH         = DEFAULT_DEPTH,
   parameter int AFULL_THRESH  = DEPTH - DEFAULT_AFULL_MARGIN,
   parameter int AEMPTY_THRESH = DEFAULT_AEMPTY_THRESH,
   parameter int POINTER_WIDTH = $clog2(DEPTH)
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         din,
   output logic                     full,
   output logic                     almost_full,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         dout,
   output logic                     valid,
   output logic                     empty,
   output logic                     almost_empty,
   output logic [POINTER_WIDTH:0]   count,
   output logic                     overflow,
   output logic                     underflow,
   input  logic                     clr_err
);

   localparam int CW = occupancy_width(POINTER_WIDTH);

   localparam logic [POINTER_WIDTH:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [POINTER_WIDTH:0] AFULL_C  = CW'(AFULL_THRESH);
   localparam logic [POINTER_WIDTH:0] AEMPTY_C = CW'(AEMPTY_THRESH);

   logic [POINTER_WIDTH-1:0] wr_ptr;
   logic [POINTER_WIDTH-1:0] rd_ptr;
   logic                     go_rd;
   logic                     go_wr;

   // A read needs data present; a write needs room, or a read in the same
   // cycle that frees the slot being written (write-through at full).
   assign go_rd = rd_en & ~empty;
   assign go_wr = wr_en & (~full | go_rd);

   // Status flags are pure compares on the registered count, so they only
   // move on clock edges or reset.
   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AFULL_C);
   assign almost_empty = (count <= AEMPTY_C);

   // Read and write pointers, each wrapping explicitly at DEPTH-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (go_wr) begin
            wr_ptr <= POINTER_WIDTH'(wrap_next(32'(wr_ptr), DEPTH));
         end
         if (go_rd) begin
            rd_ptr <= POINTER_WIDTH'(wrap_next(32'(rd_ptr), DEPTH));
         end
      end
   end

   // Occupancy: a simultaneous push and pop leaves the count where it is.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else begin
         case ({go_wr, go_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky error flags. A new error in the same cycle as clr_err keeps the
   // flag set so no event is ever lost. A read of an empty FIFO counts as an
   // underflow even when a write lands in that same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en & ~go_wr) begin
            overflow <= 1'b1;
         end else if (clr_err) begin
            overflow <= 1'b0;
         end
         if (rd_en & empty) begin
            underflow <= 1'b1;
         end else if (clr_err) begin
            underflow <= 1'b0;
         end
      end
   end

   fifo_ram #(
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (POINTER_WIDTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (go_wr),
      .wr_addr (wr_ptr),
      .wr_data (din),
      .rd_en   (go_rd),
      .rd_addr (rd_ptr),
      .rd_data (dout)
   );

`ifdef FIFO_FWFT_EN
   // Fall-through: the head word is valid whenever anything is stored.
   assign valid = ~empty;
`else
   // Registered read: valid marks the single cycle after an accepted read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
      end else begin
         valid <= go_rd;
      end
   end
`endif

endmodule
